// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel counts 0..period-1 and emits a registered square wave that is
// high for the first `high` counts, plus a one-cycle tick on the last count.
// Period/high are reprogrammed through a single-entry valid/ready slot and
// take effect only at a period boundary, on a disabled channel, or on sync.
module multi_clk_divider #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int CH_W         = 2,
    parameter int RESET_PERIOD = 100_000,
    parameter int RESET_HIGH   = 50_000
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // Per-channel divider state.
    logic [CNT_W-1:0] ctr      [NUM_CH];
    logic [CNT_W-1:0] period   [NUM_CH];
    logic [CNT_W-1:0] high     [NUM_CH];

    // High time used for this edge's output: the pending value when it lands now.
    logic [CNT_W-1:0] high_eff [NUM_CH];

    // Single pending configuration slot.
    logic             pend_vld;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;

    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic              apply_any;
    logic              cfg_fire;
    logic              cfg_ok;

    // A request is usable only if it targets an existing channel and the
    // waveform has at least one high and one low cycle.
    function automatic logic cfg_is_valid(
        input logic [CH_W-1:0]  ch,
        input logic [CNT_W-1:0] p,
        input logic [CNT_W-1:0] h
    );
        logic ch_ok;
        ch_ok = (32'(ch) < NUM_CH);
        return ch_ok && (p >= CNT_W'(2)) && (h != '0) && (h < p);
    endfunction

    // Boundary detection and pending-apply decision for every channel.
    always_comb begin
        wrap      = '0;
        apply     = '0;
        apply_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            high_eff[i] = high[i];
            wrap[i]     = (ctr[i] == period[i] - CNT_W'(1));
            apply[i]    = pend_vld && (pend_ch == CH_W'(i)) &&
                          (sync || !en[i] || wrap[i]);
            if (apply[i]) begin
                high_eff[i] = pend_high;
            end
        end
        apply_any = |apply;
        cfg_fire  = cfg_valid && cfg_ready;
        cfg_ok    = cfg_is_valid(cfg_ch, cfg_period, cfg_high);
    end

    // Counters and registered outputs: sync beats disable beats run.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctr[i]    <= '0;
                period[i] <= CNT_W'(RESET_PERIOD);
                high[i]   <= CNT_W'(RESET_HIGH);
            end
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply[i]) begin
                    period[i] <= pend_period;
                    high[i]   <= pend_high;
                end
                if (sync) begin
                    ctr[i]     <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= en[i] && (high_eff[i] != '0);
                end else if (!en[i]) begin
                    ctr[i]     <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                end else begin
                    // A run-time apply only happens on wrap, so ctr returns to 0 either way.
                    ctr[i]     <= wrap[i] ? '0 : ctr[i] + CNT_W'(1);
                    clk_out[i] <= (ctr[i] < high_eff[i]);
                    tick[i]    <= wrap[i];
                end
            end
        end
    end

    // Config handshake, pending slot and sticky error flag.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_vld    <= 1'b0;
            pend_ch     <= '0;
            pend_period <= '0;
            pend_high   <= '0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
        end else if (cfg_fire) begin
            if (cfg_ok) begin
                pend_vld    <= 1'b1;
                pend_ch     <= cfg_ch;
                pend_period <= cfg_period;
                pend_high   <= cfg_high;
                cfg_ready   <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (apply_any) begin
            pend_vld  <= 1'b0;
            cfg_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Scoreboard bench for multi_clk_divider: driver steps a behavioural model and
// queues expected outputs, an independent monitor compares on the falling edge.
module tb_multi_clk_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
    localparam int RST_P  = 40;
    localparam int RST_H  = 20;

    logic              clk = 1'b0;
    logic              CPU_RESETN = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    multi_clk_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W),
        .RESET_PERIOD(RST_P), .RESET_HIGH(RST_H)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tk;
        logic              rdy;
        logic              err;
    } exp_t;

    typedef struct {
        int ch;
        int p;
        int h;
    } cfg_t;

    exp_t exp_q[$];
    cfg_t pend_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: waveform position, period and high per channel.
    int                m_ctr [NUM_CH];
    int                m_per [NUM_CH];
    int                m_hi  [NUM_CH];
    logic [NUM_CH-1:0] m_clk;
    logic [NUM_CH-1:0] m_tick;
    logic              m_ready;
    logic              m_err;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_ctr[c] = 0;
            m_per[c] = RST_P;
            m_hi[c]  = RST_H;
        end
        m_clk   = '0;
        m_tick  = '0;
        m_ready = 1'b1;
        m_err   = 1'b0;
        pend_q.delete();
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        int   ac;
        int   pc;
        bit   last;
        exp_t e;
        ac = -1;
        if (pend_q.size() > 0) begin
            pc = pend_q[0].ch;
            if (sync || !en[pc] || (m_ctr[pc] == m_per[pc] - 1)) ac = pc;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            last = (m_ctr[c] == m_per[c] - 1);
            if (c == ac) begin
                m_per[c] = pend_q[0].p;
                m_hi[c]  = pend_q[0].h;
            end
            if (sync) begin
                m_clk[c]  = en[c] && (m_hi[c] > 0);
                m_tick[c] = 1'b0;
                m_ctr[c]  = 0;
            end else if (!en[c]) begin
                m_clk[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_ctr[c]  = 0;
            end else begin
                m_clk[c]  = (m_ctr[c] < m_hi[c]);
                m_tick[c] = last;
                m_ctr[c]  = last ? 0 : m_ctr[c] + 1;
            end
        end
        if (ac >= 0) begin
            void'(pend_q.pop_front());
            m_ready = 1'b1;
        end else if (cfg_valid && m_ready) begin
            if (int'(cfg_ch) < NUM_CH && int'(cfg_period) >= 2 &&
                int'(cfg_high) >= 1 && int'(cfg_high) <= int'(cfg_period) - 1) begin
                pend_q.push_back('{int'(cfg_ch), int'(cfg_period), int'(cfg_high)});
                m_ready = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        e.clk = m_clk;
        e.tk  = m_tick;
        e.rdy = m_ready;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs to the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, cfg_ready, cfg_err} !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t clk_out=%b want %b tick=%b want %b ready=%b want %b err=%b want %b",
                         $time, clk_out, e.clk, tick, e.tk, cfg_ready, e.rdy, cfg_err, e.err);
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Hold a config request until it is transferred, bounded in cycles.
    task automatic send_cfg(input int ch, input int p, input int h);
        bit was_ready;
        bit done;
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            was_ready = cfg_ready;
            cycle();
            done = was_ready;
        end
        cfg_valid = 1'b0;
        if (!done) check("cfg_transfer_timeout", 0, 1);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!cfg_ready && k < 300) begin
            cycle();
            k++;
        end
        check(name, int'(cfg_ready), 1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({clk_out, tick, cfg_ready, cfg_err} !== {{NUM_CH{1'b0}}, {NUM_CH{1'b0}}, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL %s got clk_out=%b tick=%b ready=%b err=%b expected 0/0/1/0",
                     name, clk_out, tick, cfg_ready, cfg_err);
        end
    endtask

    // Count highs and ticks of one channel over n cycles, sampled after each edge.
    task automatic measure(input int ch, input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            highs += int'(clk_out[ch]);
            ticks += int'(tick[ch]);
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int  hi_cnt;
        int  tk_cnt;
        bit  was_ready;
        bit  done;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        CPU_RESETN = 1'b1;

        // Reset defaults on channel 0 only.
        en = 4'b0001;
        run(3 * RST_P);

        // Program disabled ch1 to P=2 H=1, then enable it.
        send_cfg(1, 2, 1);
        cycle();
        check("ch1_cfg_ready_back", int'(cfg_ready), 1);
        en = 4'b0011;
        cycle();
        measure(1, 20, hi_cnt, tk_cnt);
        check("ch1_p2_highs", hi_cnt, 10);
        check("ch1_p2_ticks", tk_cnt, 10);

        // Reprogram running ch0 mid-period; old period must finish first.
        run(7);
        send_cfg(0, 10, 3);
        check("ch0_pending_not_ready", int'(cfg_ready), 0);
        wait_ready("ch0_apply_ready");
        measure(0, 20, hi_cnt, tk_cnt);
        check("ch0_p10_highs", hi_cnt, 6);
        check("ch0_p10_ticks", tk_cnt, 2);

        // Invalid requests: error flag, no storage, slot stays free.
        send_cfg(2, 1, 1);
        send_cfg(2, 5, 0);
        send_cfg(2, 8, 8);
        send_cfg(7, 6, 2);
        cycle();
        check("invalid_err", int'(cfg_err), 1);
        check("invalid_ready", int'(cfg_ready), 1);
        run(12);

        // Phase alignment with sync on ch2/ch3.
        send_cfg(2, 6, 2);
        send_cfg(3, 4, 1);
        run(2);
        en = 4'b1111;
        run(5 + $urandom_range(0, 9));
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync_ch2_ch3_high", int'(clk_out[3:2]), 3);
        run(14);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                cfg_valid  = 1'b1;
                cfg_ch     = CH_W'($urandom_range(0, 7));
                cfg_period = CNT_W'($urandom_range(0, 14));
                cfg_high   = CNT_W'($urandom_range(0, 14));
            end
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) en = NUM_CH'($urandom);
            was_ready = cfg_ready;
            cycle();
            if (cfg_valid && was_ready) cfg_valid = 1'b0;
            sync = 1'b0;
        end
        en = 4'b1111;
        done = !cfg_valid;
        for (int k = 0; k < 300 && !done; k++) begin
            was_ready = cfg_ready;
            cycle();
            done = was_ready;
        end
        cfg_valid = 1'b0;
        if (!done) check("random_drain_timeout", 0, 1);
        wait_ready("random_drain_ready");

        // Asynchronous reset while a config is pending.
        send_cfg(0, 9, 4);
        check("pending_before_reset", int'(cfg_ready), 0);
        @(negedge clk);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check_reset_outputs("async_reset_immediate");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        CPU_RESETN = 1'b1;
        en = 4'b0001;
        run(2 * RST_P + 5);
        measure(0, RST_P, hi_cnt, tk_cnt);
        check("post_reset_highs", hi_cnt, RST_H);
        check("post_reset_ticks", tk_cnt, 1);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
